// File: rtl/map_tile_writer.sv
// Write side of the dual-port tile-map RAM: turns SET / FILL / CLEAR commands
// into a stream of one-tile-per-clock writes with incremental addressing.
module map_tile_writer #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 90,
  localparam int AW    = $clog2(WIDTH * HEIGHT)
) (
  input  logic          pixel_clk_in,
  input  logic          rst_in,
  input  logic          cmd_valid_in,
  output logic          cmd_ready_out,
  input  logic [1:0]    cmd_op_in,
  input  logic [7:0]    cmd_x0_in,
  input  logic [6:0]    cmd_y0_in,
  input  logic [7:0]    cmd_x1_in,
  input  logic [6:0]    cmd_y1_in,
  input  logic [3:0]    cmd_tile_in,
  output logic [AW-1:0] wr_addr_out,
  output logic [3:0]    wr_data_out,
  output logic          wr_en_out,
  output logic          busy_out,
  output logic          done_out,
  output logic          err_out
);

  localparam logic [1:0]    OP_SET   = 2'd0;
  localparam logic [1:0]    OP_FILL  = 2'd1;
  localparam logic [1:0]    OP_CLEAR = 2'd2;
  localparam logic [1:0]    OP_RSVD  = 2'd3;
  localparam logic [7:0]    W8       = 8'(WIDTH);
  localparam logic [6:0]    H7       = 7'(HEIGHT);
  localparam logic [7:0]    XMAX     = 8'(WIDTH - 1);
  localparam logic [6:0]    YMAX     = 7'(HEIGHT - 1);
  localparam logic [AW-1:0] W_AW     = AW'(WIDTH);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_WRITE, S_DONE, S_ERR} state_t;

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [7:0]    x0_q, x0_d, x1_q, x1_d, cur_x_q, cur_x_d;
  logic [6:0]    y0_q, y0_d, y1_q, y1_d, cur_y_q, cur_y_d;
  logic [3:0]    tile_q, tile_d, data_q, data_d;
  logic [AW-1:0] row_base_q, row_base_d, addr_q, addr_d;
  logic          wr_en_q, wr_en_d, busy_q, busy_d, done_q, done_d;
  logic          err_q, err_d, ready_q, ready_d;

  logic [7:0]    ex0, ex1;
  logic [6:0]    ey0, ey1;
  logic [AW-1:0] start_addr;
  logic          bad_cmd;

  // SET and CLEAR are folded into rectangle bounds so one write loop serves all ops.
  always_comb begin
    ex0 = x0_q;
    ex1 = x1_q;
    ey0 = y0_q;
    ey1 = y1_q;
    case (op_q)
      OP_SET: begin
        ex1 = x0_q;
        ey1 = y0_q;
      end
      OP_CLEAR: begin
        ex0 = 8'd0;
        ex1 = XMAX;
        ey0 = 7'd0;
        ey1 = YMAX;
      end
      default: ;
    endcase
    start_addr = AW'(ex0) + AW'(ey0) * W_AW;
    bad_cmd = (op_q == OP_RSVD)
           || ((op_q != OP_CLEAR) && ((x0_q >= W8) || (y0_q >= H7)))
           || ((op_q == OP_FILL) && ((x1_q >= W8) || (y1_q >= H7)
                                     || (x0_q > x1_q) || (y0_q > y1_q)));
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    tile_d     = tile_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wr_en_d    = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    ready_d    = ready_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_in && ready_q) begin
          op_d    = cmd_op_in;
          x0_d    = cmd_x0_in;
          y0_d    = cmd_y0_in;
          x1_d    = cmd_x1_in;
          y1_d    = cmd_y1_in;
          tile_d  = cmd_tile_in;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (bad_cmd) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          x0_d       = ex0;
          x1_d       = ex1;
          y1_d       = ey1;
          cur_x_d    = ex0;
          cur_y_d    = ey0;
          row_base_d = start_addr;
          addr_d     = start_addr;
          data_d     = tile_q;
          wr_en_d    = 1'b1;
          state_d    = S_WRITE;
        end
      end
      S_WRITE: begin
        if ((cur_x_q == x1_q) && (cur_y_q == y1_q)) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          wr_en_d = 1'b1;
          if (cur_x_q == x1_q) begin
            cur_x_d    = x0_q;
            cur_y_d    = cur_y_q + 7'd1;
            row_base_d = row_base_q + W_AW;
            addr_d     = row_base_q + W_AW;
          end else begin
            cur_x_d = cur_x_q + 8'd1;
            addr_d  = addr_q + AW'(1);
          end
        end
      end
      S_DONE, S_ERR: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      op_q       <= 2'd0;
      x0_q       <= 8'd0;
      y0_q       <= 7'd0;
      x1_q       <= 8'd0;
      y1_q       <= 7'd0;
      tile_q     <= 4'd0;
      cur_x_q    <= 8'd0;
      cur_y_q    <= 7'd0;
      row_base_q <= '0;
      addr_q     <= '0;
      data_q     <= 4'd0;
      wr_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      tile_q     <= tile_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wr_en_q    <= wr_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
    end
  end

  assign cmd_ready_out = ready_q;
  assign wr_addr_out   = addr_q;
  assign wr_data_out   = data_q;
  assign wr_en_out     = wr_en_q;
  assign busy_out      = busy_q;
  assign done_out      = done_q;
  assign err_out       = err_q;

endmodule

// File: tb/tb_map_tile_writer.sv
// Scoreboard bench for map_tile_writer: a rectangle-level model queues the
// expected write stream at accept time, and a monitor consumes it as the DUT emits.
module tb_map_tile_writer;

  localparam int WIDTH  = 160;
  localparam int HEIGHT = 90;
  localparam int AW     = $clog2(WIDTH * HEIGHT);
  localparam int BUDGET = 20000;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid_in;
  logic          cmd_ready_out;
  logic [1:0]    cmd_op_in;
  logic [7:0]    cmd_x0_in;
  logic [6:0]    cmd_y0_in;
  logic [7:0]    cmd_x1_in;
  logic [6:0]    cmd_y1_in;
  logic [3:0]    cmd_tile_in;
  logic [AW-1:0] wr_addr_out;
  logic [3:0]    wr_data_out;
  logic          wr_en_out;
  logic          busy_out;
  logic          done_out;
  logic          err_out;

  map_tile_writer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .pixel_clk_in (clk),
    .rst_in       (rst),
    .cmd_valid_in (cmd_valid_in),
    .cmd_ready_out(cmd_ready_out),
    .cmd_op_in    (cmd_op_in),
    .cmd_x0_in    (cmd_x0_in),
    .cmd_y0_in    (cmd_y0_in),
    .cmd_x1_in    (cmd_x1_in),
    .cmd_y1_in    (cmd_y1_in),
    .cmd_tile_in  (cmd_tile_in),
    .wr_addr_out  (wr_addr_out),
    .wr_data_out  (wr_data_out),
    .wr_en_out    (wr_en_out),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .err_out      (err_out)
  );

  always #5 clk = ~clk;

  // kind: 0 = write, 1 = done pulse, 2 = error pulse
  typedef struct {
    int kind;
    int addr;
    int data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vec_count = 0;
  int   err_count = 0;
  bit   in_burst  = 1'b0;
  bit   prev_end  = 1'b0;

  task automatic check_output(input string name, input int actual, input int expected);
    vec_count++;
    if (actual != expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected outcome straight from the command rules: validity, then the cell list.
  function automatic bit push_expected(input int op, input int x0, input int y0,
                                       input int x1, input int y1, input int tile);
    bit bad;
    bad = (op == 3)
       || ((op != 2) && ((x0 >= WIDTH) || (y0 >= HEIGHT)))
       || ((op == 1) && ((x1 >= WIDTH) || (y1 >= HEIGHT) || (x0 > x1) || (y0 > y1)));
    if (bad) begin
      exp_q.push_back('{2, 0, 0});
    end else begin
      if (op == 0) begin
        exp_q.push_back('{0, x0 + y0 * WIDTH, tile});
      end else if (op == 1) begin
        for (int y = y0; y <= y1; y++)
          for (int x = x0; x <= x1; x++)
            exp_q.push_back('{0, x + y * WIDTH, tile});
      end else begin
        for (int a = 0; a < WIDTH * HEIGHT; a++)
          exp_q.push_back('{0, a, tile});
      end
      exp_q.push_back('{1, 0, 0});
    end
    return bad;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      in_burst = 1'b0;
      prev_end = 1'b0;
    end else begin
      if (prev_end) begin
        check_output("ready_after_end", {30'd0, cmd_ready_out, busy_out}, 2);
        prev_end = 1'b0;
      end
      if (wr_en_out || done_out || err_out) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_output", {29'd0, wr_en_out, done_out, err_out}, 0);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.kind == 0) begin
            check_output("write_flags", {29'd0, wr_en_out, done_out, err_out}, 4);
            check_output("write_addr", int'(wr_addr_out), mon_e.addr);
            check_output("write_data", int'(wr_data_out), mon_e.data);
          end else if (mon_e.kind == 1) begin
            check_output("done_flags", {29'd0, wr_en_out, done_out, err_out, busy_out}, 5);
            prev_end = 1'b1;
          end else begin
            check_output("err_flags", {29'd0, wr_en_out, done_out, err_out, busy_out}, 3);
            prev_end = 1'b1;
          end
        end
      end else if (in_burst) begin
        check_output("burst_gap", 0, 1);
      end
      in_burst = wr_en_out;
    end
  end

  task automatic apply_stimulus(input logic [1:0] op, input logic [7:0] x0, input logic [6:0] y0,
                                input logic [7:0] x1, input logic [6:0] y1, input logic [3:0] tile,
                                input bit hold);
    bit accepted;
    bit bad;
    accepted = 1'b0;
    bad      = 1'b0;
    @(negedge clk);
    cmd_op_in    = op;
    cmd_x0_in    = x0;
    cmd_y0_in    = y0;
    cmd_x1_in    = x1;
    cmd_y1_in    = y1;
    cmd_tile_in  = tile;
    cmd_valid_in = 1'b1;
    for (int n = 0; n < BUDGET && !accepted; n++) begin
      if (cmd_ready_out) begin
        @(posedge clk);
        bad = push_expected(int'(op), int'(x0), int'(y0), int'(x1), int'(y1), int'(tile));
        accepted = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!accepted) begin
      check_output("accept_timeout", 0, 1);
      cmd_valid_in = 1'b0;
      return;
    end
    if (!hold) begin
      #1 cmd_valid_in = 1'b0;
    end
    @(negedge clk);
    check_output("check_cycle", {28'd0, cmd_ready_out, busy_out, wr_en_out, err_out}, 4);
    @(negedge clk);
    check_output("first_response", {30'd0, wr_en_out, err_out}, bad ? 1 : 2);
    cmd_valid_in = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int n = 0; n < BUDGET && !idle; n++) begin
      @(negedge clk);
      idle = cmd_ready_out;
    end
    if (!idle) check_output("idle_timeout", 0, 1);
    else check_output("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    logic [1:0] r_op;
    logic [7:0] r_x0, r_x1;
    logic [6:0] r_y0, r_y1;
    int         pick;

    rst          = 1'b1;
    cmd_valid_in = 1'b0;
    cmd_op_in    = 2'd0;
    cmd_x0_in    = 8'd0;
    cmd_y0_in    = 7'd0;
    cmd_x1_in    = 8'd0;
    cmd_y1_in    = 7'd0;
    cmd_tile_in  = 4'd0;
    #1;
    check_output("reset_ready", int'(cmd_ready_out), 1);
    check_output("reset_flags", {28'd0, wr_en_out, busy_out, done_out, err_out}, 0);
    check_output("reset_addr_data", int'(wr_addr_out) + int'(wr_data_out), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    apply_stimulus(2'd0, 8'd5, 7'd3, 8'd0, 7'd0, 4'd2, 1'b0);
    wait_idle();
    apply_stimulus(2'd1, 8'd0, 7'd0, 8'd2, 7'd1, 4'd1, 1'b0);
    wait_idle();
    apply_stimulus(2'd2, 8'd200, 7'd120, 8'd7, 7'd3, 4'd0, 1'b0);
    wait_idle();
    apply_stimulus(2'd1, 8'd3, 7'd0, 8'd2, 7'd0, 4'd5, 1'b0);
    wait_idle();
    apply_stimulus(2'd0, 8'd160, 7'd0, 8'd0, 7'd0, 4'd5, 1'b0);
    wait_idle();
    apply_stimulus(2'd3, 8'd1, 7'd1, 8'd2, 7'd2, 4'd5, 1'b0);
    wait_idle();
    apply_stimulus(2'd0, 8'd159, 7'd89, 8'd0, 7'd0, 4'd15, 1'b0);
    wait_idle();
    apply_stimulus(2'd1, 8'd150, 7'd89, 8'd159, 7'd89, 4'd3, 1'b0);
    wait_idle();
    apply_stimulus(2'd1, 8'd40, 7'd80, 8'd40, 7'd89, 4'd6, 1'b0);
    wait_idle();
    apply_stimulus(2'd1, 8'd77, 7'd44, 8'd77, 7'd44, 4'd11, 1'b0);
    wait_idle();
    apply_stimulus(2'd1, 8'd0, 7'd90, 8'd3, 7'd90, 4'd11, 1'b0);
    wait_idle();

    // Second command held valid across a busy FILL must be taken exactly once.
    apply_stimulus(2'd1, 8'd10, 7'd10, 8'd19, 7'd12, 4'd7, 1'b0);
    apply_stimulus(2'd0, 8'd1, 7'd1, 8'd0, 7'd0, 4'd9, 1'b1);
    wait_idle();

    apply_stimulus(2'd1, 8'd0, 7'd0, 8'd50, 7'd10, 4'd8, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_output("midreset_wr_en", int'(wr_en_out), 0);
    check_output("midreset_ready_busy", {30'd0, cmd_ready_out, busy_out}, 2);
    exp_q.delete();
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check_output("post_reset_ready", int'(cmd_ready_out), 1);
    apply_stimulus(2'd0, 8'd7, 7'd2, 8'd0, 7'd0, 4'd4, 1'b0);
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      pick = int'($urandom_range(0, 9));
      r_op = (pick == 0) ? 2'd3 : ((pick < 5) ? 2'd0 : 2'd1);
      r_x0 = 8'($urandom_range(0, 170));
      r_y0 = 7'($urandom_range(0, 95));
      r_x1 = ($urandom_range(0, 4) == 0) ? r_x0 - 8'd1 : r_x0 + 8'($urandom_range(0, 7));
      r_y1 = ($urandom_range(0, 4) == 0) ? r_y0 - 7'd1 : r_y0 + 7'($urandom_range(0, 4));
      apply_stimulus(r_op, r_x0, r_y0, r_x1, r_y1, 4'($urandom_range(0, 15)), 1'b0);
      wait_idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
